// File: rtl/ram_pkg.sv
// Shared types and constants for the scratch-RAM controller and its RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ram_pkg;

   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int RAM_DEPTH      = 2 ** DEF_ADDR_WIDTH;

   // RAM OPCODE pin encoding
   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   typedef enum logic [3:0] {
      ST_CLR_SETUP,
      ST_CLR_STROBE,
      ST_CLR_HOLD,
      ST_IDLE,
      ST_WR_SETUP,
      ST_WR_STROBE,
      ST_WR_HOLD,
      ST_RD_ADDR,
      ST_RSP
   } state_t;

endpackage

// File: rtl/ram.sv
// Scratch RAM: combinational read of the addressed cell, write while OPCODE is high.
// Latency: read data follows ADDRESS in the same cycle; write lands at the clock edge.
// Backpressure: none, always ready.
module ram
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic [ADDR_WIDTH-1:0] ADDRESS,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   input  logic                  OPCODE,
   output logic [DATA_WIDTH-1:0] DATA_OUT
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // store DATA_IN into the addressed cell while the write strobe is high
   always_ff @(posedge CLK) begin
      if (OPCODE == OP_WRITE) begin
         r_mem[ADDRESS] <= DATA_IN;
      end
   end

   assign DATA_OUT = r_mem[ADDRESS];

endmodule

// File: rtl/ram_ctrl.sv
// Sequencer between CPU requests and the scratch RAM pins (setup/strobe/hold writes, zero-fill after reset).
// Latency: write 4 cycles accept-to-ready; read response valid 2 cycles after accept.
// Backpressure: REQ_READY only in IDLE; a held response (RSP_READY low) stalls all new requests.
module ram_ctrl
   import ram_pkg::*;
#(
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  REQ_VALID,
   output logic                  REQ_READY,
   input  logic                  REQ_WRITE,
   input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
   input  logic [DATA_WIDTH-1:0] REQ_WDATA,
   output logic                  RSP_VALID,
   input  logic                  RSP_READY,
   output logic [DATA_WIDTH-1:0] RSP_DATA,
   output logic [ADDR_WIDTH-1:0] RAM_ADDRESS,
   output logic [DATA_WIDTH-1:0] RAM_DATA_IN,
   output logic                  RAM_OPCODE,
   input  logic [DATA_WIDTH-1:0] RAM_DATA_OUT,
   output logic                  BUSY
);

   // Zero-fill walks every cell; without it the controller comes out of reset idle.
   localparam state_t                RST_STATE = CLEAR_ON_RESET ? ST_CLR_SETUP : ST_IDLE;
   localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = '1;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_clr_cnt;
   logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;
   logic [ADDR_WIDTH-1:0] r_ram_address;
   logic [ADDR_WIDTH-1:0] w_ram_address_nxt;
   logic [DATA_WIDTH-1:0] r_ram_data_in;
   logic [DATA_WIDTH-1:0] w_ram_data_in_nxt;
   logic                  r_ram_opcode;
   logic                  w_ram_opcode_nxt;
   logic                  r_rsp_valid;
   logic                  w_rsp_valid_nxt;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic [DATA_WIDTH-1:0] w_rsp_data_nxt;

   // Next-state and next-output logic. Every RAM pin is registered, so the
   // opcode computed here is the value for the *next* state: it is raised only
   // on the transition into a STROBE state, which keeps the strobe glitch-free
   // and exactly one cycle wide with address/data already settled.
   always_comb begin
      w_state_nxt       = r_state;
      w_clr_cnt_nxt     = r_clr_cnt;
      w_ram_address_nxt = r_ram_address;
      w_ram_data_in_nxt = r_ram_data_in;
      w_ram_opcode_nxt  = OP_READ;
      w_rsp_valid_nxt   = r_rsp_valid;
      w_rsp_data_nxt    = r_rsp_data;

      case (r_state)
         ST_CLR_SETUP: begin
            w_state_nxt      = ST_CLR_STROBE;
            w_ram_opcode_nxt = OP_WRITE;
         end
         ST_CLR_STROBE: begin
            w_state_nxt = ST_CLR_HOLD;
         end
         ST_CLR_HOLD: begin
            // counter wraps back to 0 after the last cell
            w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
            if (r_clr_cnt == CNT_LAST) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt       = ST_CLR_SETUP;
               w_ram_address_nxt = r_clr_cnt + ADDR_WIDTH'(1);
               w_ram_data_in_nxt = '0;
            end
         end
         ST_IDLE: begin
            // REQ_READY is high exactly in this state, so REQ_VALID alone is the handshake
            if (REQ_VALID) begin
               w_ram_address_nxt = REQ_ADDR;
               w_ram_data_in_nxt = REQ_WDATA;
               w_state_nxt       = REQ_WRITE ? ST_WR_SETUP : ST_RD_ADDR;
            end
         end
         ST_WR_SETUP: begin
            w_state_nxt      = ST_WR_STROBE;
            w_ram_opcode_nxt = OP_WRITE;
         end
         ST_WR_STROBE: begin
            w_state_nxt = ST_WR_HOLD;
         end
         ST_WR_HOLD: begin
            w_state_nxt = ST_IDLE;
         end
         ST_RD_ADDR: begin
            // address has been stable for a full cycle, capture the RAM's combinational output
            w_rsp_data_nxt  = RAM_DATA_OUT;
            w_rsp_valid_nxt = 1'b1;
            w_state_nxt     = ST_RSP;
         end
         ST_RSP: begin
            // RSP_DATA is deliberately left untouched after the handshake
            if (RSP_READY) begin
               w_rsp_valid_nxt = 1'b0;
               w_state_nxt     = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = RST_STATE;
         end
      endcase
   end

   // State and registered outputs; reset drops the strobe and discards any pending response.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state       <= RST_STATE;
         r_clr_cnt     <= '0;
         r_ram_address <= '0;
         r_ram_data_in <= '0;
         r_ram_opcode  <= OP_READ;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_clr_cnt     <= w_clr_cnt_nxt;
         r_ram_address <= w_ram_address_nxt;
         r_ram_data_in <= w_ram_data_in_nxt;
         r_ram_opcode  <= w_ram_opcode_nxt;
         r_rsp_valid   <= w_rsp_valid_nxt;
         r_rsp_data    <= w_rsp_data_nxt;
      end
   end

   assign REQ_READY   = (r_state == ST_IDLE);
   assign BUSY        = (r_state != ST_IDLE);
   assign RSP_VALID   = r_rsp_valid;
   assign RSP_DATA    = r_rsp_data;
   assign RAM_ADDRESS = r_ram_address;
   assign RAM_DATA_IN = r_ram_data_in;
   assign RAM_OPCODE  = r_ram_opcode;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl driving a ram instance: zero-fill, write/read vectors, stalls, mid-operation reset.
// Latency: checks exact cycle positions of strobe, response and ready.
// Backpressure: exercises RSP_READY held low.
module tb_ram_ctrl;
   import ram_pkg::*;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       REQ_VALID = 1'b0;
   logic       REQ_READY;
   logic       REQ_WRITE = 1'b0;
   logic [3:0] REQ_ADDR = 4'h0;
   logic [7:0] REQ_WDATA = 8'h00;
   logic       RSP_VALID;
   logic       RSP_READY = 1'b1;
   logic [7:0] RSP_DATA;
   logic [3:0] RAM_ADDRESS;
   logic [7:0] RAM_DATA_IN;
   logic       RAM_OPCODE;
   logic [7:0] RAM_DATA_OUT;
   logic       BUSY;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      bit         wr;
      logic [3:0] addr;
      logic [7:0] data;   // write data, or expected read data
      int         stall;  // cycles RSP_READY is held low after RSP_VALID rises
   } vec_t;

   vec_t vecs[10];

   ram_ctrl #(
      .ADDR_WIDTH    (4),
      .DATA_WIDTH    (8),
      .CLEAR_ON_RESET(1'b1)
   ) u_dut (
      .CLK         (CLK),
      .RST         (RST),
      .REQ_VALID   (REQ_VALID),
      .REQ_READY   (REQ_READY),
      .REQ_WRITE   (REQ_WRITE),
      .REQ_ADDR    (REQ_ADDR),
      .REQ_WDATA   (REQ_WDATA),
      .RSP_VALID   (RSP_VALID),
      .RSP_READY   (RSP_READY),
      .RSP_DATA    (RSP_DATA),
      .RAM_ADDRESS (RAM_ADDRESS),
      .RAM_DATA_IN (RAM_DATA_IN),
      .RAM_OPCODE  (RAM_OPCODE),
      .RAM_DATA_OUT(RAM_DATA_OUT),
      .BUSY        (BUSY)
   );

   ram #(
      .ADDR_WIDTH(4),
      .DATA_WIDTH(8)
   ) u_ram (
      .CLK     (CLK),
      .ADDRESS (RAM_ADDRESS),
      .DATA_IN (RAM_DATA_IN),
      .OPCODE  (RAM_OPCODE),
      .DATA_OUT(RAM_DATA_OUT)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Called in the first cycle after reset deassertion; covers the 48 fill cycles.
   task automatic check_fill();
      int pulses = 0;
      int addr_bad = 0;
      int status_bad = 0;
      for (int i = 0; i < 48; i++) begin
         if (BUSY !== 1'b1 || REQ_READY !== 1'b0) status_bad++;
         if (RAM_ADDRESS !== 4'(i / 3)) addr_bad++;
         if (RAM_OPCODE === 1'b1) begin
            if ((i % 3) != 1 || RAM_DATA_IN !== 8'h00) addr_bad++;
            pulses++;
         end
         tick();
      end
      check("fill_busy_not_ready", 32'(status_bad), 32'd0);
      check("fill_opcode_pulses", 32'(pulses), 32'd16);
      check("fill_addr_sequence", 32'(addr_bad), 32'd0);
      check("fill_done_idle", 32'({BUSY, REQ_READY}), 32'b01);
   endtask

   task automatic do_write(input logic [3:0] a, input logic [7:0] d);
      logic [3:0] seq;
      int stab_bad = 0;
      check("wr_ready", 32'(REQ_READY), 32'd1);
      REQ_VALID = 1'b1;
      REQ_WRITE = 1'b1;
      REQ_ADDR  = a;
      REQ_WDATA = d;
      tick();
      // a different request kept valid during the sequence must be ignored
      REQ_ADDR  = ~a;
      REQ_WDATA = ~d;
      for (int i = 0; i < 3; i++) begin
         seq[i] = RAM_OPCODE;
         if (RAM_ADDRESS !== a || RAM_DATA_IN !== d) stab_bad++;
         tick();
      end
      REQ_VALID = 1'b0;
      seq[3] = REQ_READY;
      // bit0 SETUP opcode=0, bit1 STROBE opcode=1, bit2 HOLD opcode=0, bit3 ready again
      check("wr_opcode_ready_seq", 32'(seq), 32'b1010);
      check("wr_addr_data_stable", 32'(stab_bad), 32'd0);
   endtask

   task automatic do_read(input logic [3:0] a, input logic [7:0] exp, input int stall);
      check("rd_ready", 32'(REQ_READY), 32'd1);
      RSP_READY = (stall == 0);
      REQ_VALID = 1'b1;
      REQ_WRITE = 1'b0;
      REQ_ADDR  = a;
      REQ_WDATA = 8'h3C;
      tick();
      REQ_VALID = 1'b0;
      check("rd_addr_cycle", 32'({RSP_VALID, REQ_READY, RAM_OPCODE, RAM_ADDRESS}), 32'({3'b000, a}));
      tick();
      check("rd_rsp_valid", 32'({RSP_VALID, REQ_READY}), 32'b10);
      check("rd_rsp_data", 32'(RSP_DATA), 32'(exp));
      if (stall > 0) begin
         int bad = 0;
         for (int i = 0; i < stall; i++) begin
            tick();
            if (RSP_VALID !== 1'b1 || RSP_DATA !== exp || REQ_READY !== 1'b0) bad++;
         end
         check("rd_stall_stable", 32'(bad), 32'd0);
         RSP_READY = 1'b1;
      end
      tick();
      check("rd_after_handshake", 32'({REQ_READY, RSP_VALID, RSP_DATA}), 32'({2'b10, exp}));
   endtask

   initial begin
      vecs[0] = '{wr: 1'b0, addr: 4'd7,  data: 8'h00, stall: 0};
      vecs[1] = '{wr: 1'b1, addr: 4'd3,  data: 8'hA5, stall: 0};
      vecs[2] = '{wr: 1'b0, addr: 4'd3,  data: 8'hA5, stall: 0};
      vecs[3] = '{wr: 1'b0, addr: 4'd3,  data: 8'hA5, stall: 5};
      vecs[4] = '{wr: 1'b1, addr: 4'd15, data: 8'hFF, stall: 0};
      vecs[5] = '{wr: 1'b1, addr: 4'd0,  data: 8'h01, stall: 0};
      vecs[6] = '{wr: 1'b0, addr: 4'd15, data: 8'hFF, stall: 0};
      vecs[7] = '{wr: 1'b0, addr: 4'd0,  data: 8'h01, stall: 0};
      vecs[8] = '{wr: 1'b1, addr: 4'd7,  data: 8'h5A, stall: 0};
      vecs[9] = '{wr: 1'b0, addr: 4'd7,  data: 8'h5A, stall: 0};

      // reset and zero-fill
      repeat (3) tick();
      check("reset_ctrl", 32'({BUSY, REQ_READY, RAM_OPCODE, RSP_VALID}), 32'b1000);
      check("reset_regs", 32'({RAM_ADDRESS, RAM_DATA_IN, RSP_DATA}), 32'd0);
      RST = 1'b0;
      check_fill();

      // directed vectors
      for (int v = 0; v < 10; v++) begin
         if (vecs[v].wr) do_write(vecs[v].addr, vecs[v].data);
         else            do_read(vecs[v].addr, vecs[v].data, vecs[v].stall);
      end

      // reset during WR_STROBE of a write to cell 9
      do_write(4'd9, 8'h33);
      REQ_VALID = 1'b1;
      REQ_WRITE = 1'b1;
      REQ_ADDR  = 4'd9;
      REQ_WDATA = 8'h77;
      tick();
      REQ_VALID = 1'b0;
      tick();
      check("abort_in_strobe", 32'(RAM_OPCODE), 32'd1);
      RST = 1'b1;
      tick();
      check("abort_outputs", 32'({RAM_OPCODE, RSP_VALID, BUSY, REQ_READY, RAM_ADDRESS, RAM_DATA_IN}),
            32'({4'b0010, 4'h0, 8'h00}));
      RST = 1'b0;
      check_fill();
      do_read(4'd9, 8'h00, 0);
      do_read(4'd7, 8'h00, 0);

      // reset while a response is pending discards it
      do_write(4'd3, 8'hC3);
      RSP_READY = 1'b0;
      REQ_VALID = 1'b1;
      REQ_WRITE = 1'b0;
      REQ_ADDR  = 4'd3;
      tick();
      REQ_VALID = 1'b0;
      tick();
      check("pending_rsp", 32'({RSP_VALID, RSP_DATA}), 32'({1'b1, 8'hC3}));
      RST = 1'b1;
      tick();
      check("pending_rsp_dropped", 32'({RSP_VALID, RSP_DATA}), 32'd0);
      RST = 1'b0;
      RSP_READY = 1'b1;
      check_fill();
      do_read(4'd3, 8'h00, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
